mem_port_arbiter: RTL and testbench

Shares the processor's single-port synchronous data/instruction RAM between the instruction-fetch (IF) requester and the load/store (LS) requester. Only one transaction is outstanding at a time. Arbitration uses fixed LS priority with an anti-starvation limit for IF. The block sits between the processor core's fetch/memory stages and the RAM macro, and drives all RAM control signals.

---
 rtl/mem_port_arbiter.sv | 84 ++++++++
 tb/tb_mem_port_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port RAM between instruction fetch and load/store,
// one transaction at a time, LS priority with a bounded IF starvation window.
module mem_port_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 16,
  parameter int RD_LAT   = 1,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          ls_req,
  input  logic          ls_we,
  input  logic [AW-1:0] ls_addr,
  input  logic [DW-1:0] ls_wdata,
  output logic          ls_gnt,
  output logic          ls_rvalid,
  output logic [DW-1:0] ls_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;
  localparam int LW = RD_LAT > 1 ? $clog2(RD_LAT) : 1;
  localparam int CW = $clog2(MAX_WAIT + 1);
  state_t state, nxt;
  logic owner;
  logic we_q;
  logic [LW-1:0] lat_cnt;
  logic [CW-1:0] wait_cnt;
  logic idle, ls_win, if_win;
  // Grants are masked while reset is asserted so no pulse leaks out during reset.
  always_comb begin
    idle = state == IDLE && reset;
    ls_win = idle && ls_req && !(if_req && wait_cnt == CW'(MAX_WAIT));
    if_win = idle && if_req && !ls_win;
    if_gnt = if_win;
    ls_gnt = ls_win;
    busy = state != IDLE;
    if_rvalid = state == RESP && !owner;
    ls_rvalid = state == RESP && owner;
    nxt = state == IDLE   ? ((ls_win || if_win) ? ACCESS : IDLE) :
          state == ACCESS ? (we_q ? IDLE : WAIT) :
          state == WAIT   ? (lat_cnt == '0 ? RESP : WAIT) : IDLE;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= nxt;
  // wait_cnt cannot overflow: an LS win with if_req high implies wait_cnt < MAX_WAIT.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      owner <= 1'b0;
      we_q <= 1'b0;
      lat_cnt <= '0;
      wait_cnt <= '0;
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      if_rdata <= '0;
      ls_rdata <= '0;
    end else begin
      mem_en <= ls_win || if_win;
      mem_we <= ls_win && ls_we;
      if (ls_win || if_win) begin
        owner <= ls_win;
        we_q <= ls_win && ls_we;
        mem_addr <= ls_win ? ls_addr : if_addr;
        mem_wdata <= ls_win ? ls_wdata : '0;
        wait_cnt <= (ls_win && if_req) ? wait_cnt + 1'b1 : '0;
      end
      if (state == ACCESS) lat_cnt <= LW'(RD_LAT - 1);
      else if (state == WAIT && lat_cnt != '0) lat_cnt <= lat_cnt - 1'b1;
      if (state == WAIT && lat_cnt == '0 && owner) ls_rdata <= mem_rdata;
      if (state == WAIT && lat_cnt == '0 && !owner) if_rdata <= mem_rdata;
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: timeline model of the arbiter checked every cycle, plus directed
// literal checks; a second RD_LAT=3 instance covers reset during a read wait.
module tb_mem_port_arbiter;
  localparam int AW = 8, DW = 16, MW = 4, RL = 1;
  logic clk = 0, reset = 1, reset3 = 1;
  always #5 clk = ~clk;
  logic if_req = 0, ls_req = 0, ls_we = 0;
  logic [AW-1:0] if_addr = 0, ls_addr = 0;
  logic [DW-1:0] ls_wdata = 0, mem_rdata;
  logic if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_en, mem_we, busy;
  logic [DW-1:0] if_rdata, ls_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic ls_req3 = 0, z1 = 0;
  logic [AW-1:0] ls_addr3 = 0, za = 0;
  logic [DW-1:0] zd = 0, mem_rdata3;
  logic if_gnt3, if_rvalid3, ls_gnt3, ls_rvalid3, mem_en3, mem_we3, busy3;
  logic [DW-1:0] if_rdata3, ls_rdata3, mem_wdata3;
  logic [AW-1:0] mem_addr3;
  int cyc = 0, n_chk = 0, n_fail = 0;
  logic [DW-1:0] ram [256];
  logic [DW-1:0] ram3 [256];
  logic [DW-1:0] p0, p1, p2;

  mem_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RL), .MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset), .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .ls_req(ls_req), .ls_we(ls_we),
    .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid),
    .ls_rdata(ls_rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy));

  mem_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(3), .MAX_WAIT(MW)) dut3 (
    .clk(clk), .reset(reset3), .if_req(z1), .if_addr(za), .if_gnt(if_gnt3),
    .if_rvalid(if_rvalid3), .if_rdata(if_rdata3), .ls_req(ls_req3), .ls_we(z1),
    .ls_addr(ls_addr3), .ls_wdata(zd), .ls_gnt(ls_gnt3), .ls_rvalid(ls_rvalid3),
    .ls_rdata(ls_rdata3), .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3),
    .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3), .busy(busy3));

  function automatic logic [DW-1:0] init_val(input int i);
    return i == 16 ? 16'hBEEF : DW'(i * 7 + 3);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk)
    if (cyc == 0) for (int i = 0; i < 256; i++) ram[i] <= init_val(i);
    else if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
    else if (mem_en) mem_rdata <= ram[mem_addr];
  always @(posedge clk) begin
    if (cyc == 0) for (int i = 0; i < 256; i++) ram3[i] <= init_val(i);
    else if (mem_en3 && !mem_we3) p0 <= ram3[mem_addr3];
    p1 <= p0;
    p2 <= p1;
  end
  assign mem_rdata3 = p2;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // age = cycles since the current transaction was granted (0 = bus free).
  initial begin
    int age, wc;
    logic m_owner, m_we, e_ig, e_lg;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_ifrd, m_lsrd;
    logic [DW-1:0] mram [256];
    age = 0; wc = 0; m_owner = 0; m_we = 0; m_addr = 0; m_wdata = 0; m_ifrd = 0; m_lsrd = 0;
    for (int i = 0; i < 256; i++) mram[i] = init_val(i);
    forever begin
      @(negedge clk);
      e_ig = 0;
      e_lg = 0;
      if (!reset) begin
        age = 0; wc = 0; m_ifrd = 0; m_lsrd = 0;
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
      end else begin
        e_lg = age == 0 && ls_req && !(if_req && wc == MW);
        e_ig = age == 0 && if_req && !e_lg;
        if (age == RL + 2 && m_owner) m_lsrd = mram[m_addr];
        if (age == RL + 2 && !m_owner) m_ifrd = mram[m_addr];
      end
      chk("if_gnt", if_gnt, e_ig);
      chk("ls_gnt", ls_gnt, e_lg);
      chk("busy", busy, age != 0);
      chk("mem_en", mem_en, age == 1);
      chk("mem_we", mem_we, age == 1 && m_we);
      if (age == 1) chk("mem_addr", mem_addr, m_addr);
      if (age == 1 && m_we) chk("mem_wdata", mem_wdata, m_wdata);
      chk("if_rvalid", if_rvalid, age == RL + 2 && !m_owner);
      chk("ls_rvalid", ls_rvalid, age == RL + 2 && m_owner);
      chk("if_rdata", if_rdata, m_ifrd);
      chk("ls_rdata", ls_rdata, m_lsrd);
      if (reset && age == 0 && (e_lg || e_ig)) begin
        m_owner = e_lg;
        m_we = e_lg && ls_we;
        m_addr = e_lg ? ls_addr : if_addr;
        m_wdata = ls_wdata;
        wc = (e_lg && if_req) ? wc + 1 : 0;
        age = 1;
      end else if (reset && age == 1 && m_we) begin
        mram[m_addr] = m_wdata;
        age = 0;
      end else if (reset && age != 0) age = age == RL + 2 ? 0 : age + 1;
    end
  end

  task automatic idle_wait();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(output logic is_ls, output int t);
    is_ls = 0;
    t = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (if_gnt || ls_gnt) begin
        is_ls = ls_gnt;
        t = cyc;
        break;
      end
    end
    chk("gnt_timeout", t >= 0, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic g;
    int t0, t1;
    logic [9:0] order;
    #1 reset = 0;
    reset3 = 0;
    if_req = 1; ls_req = 1; if_addr = 8'h10; ls_addr = 8'h22;
    repeat (5) begin
      @(negedge clk);
      chk("rst_gnt", {if_gnt, ls_gnt}, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rvalid", {if_rvalid, ls_rvalid}, 0);
    end
    @(posedge clk);
    #1 reset = 1;
    @(negedge clk);
    chk("rel_ls_gnt", ls_gnt, 1);
    @(posedge clk);
    #1 if_req = 0; ls_req = 0;
    idle_wait();
    if_req = 1; if_addr = 8'h10;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 0) chk("ifrd_gnt", if_gnt, 1);
      if (c == 1) chk("ifrd_mem", {mem_en, mem_we, mem_addr}, {2'b10, 8'h10});
      if (c == 3) chk("ifrd_data", {if_rvalid, if_rdata}, {1'b1, 16'hBEEF});
      if (c == 4) chk("ifrd_idle", busy, 0);
      if (c == 0) begin @(posedge clk); #1 if_req = 0; end
    end
    idle_wait();
    ls_req = 1; ls_we = 1; ls_addr = 8'h22; ls_wdata = 16'h1234;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (c == 0) chk("lswr_gnt", ls_gnt, 1);
      if (c == 1) chk("lswr_mem", {mem_en, mem_we, mem_addr, mem_wdata}, {2'b11, 8'h22, 16'h1234});
      if (c == 2) chk("lswr_norv", {ls_rvalid, busy}, 0);
      if (c == 0) begin @(posedge clk); #1 ls_req = 0; ls_we = 0; end
    end
    idle_wait();
    ls_req = 1; ls_addr = 8'h22;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 0) chk("lsrd_gnt", ls_gnt, 1);
      if (c == 3) chk("lsrd_data", {ls_rvalid, ls_rdata}, {1'b1, 16'h1234});
      if (c == 0) begin @(posedge clk); #1 ls_req = 0; end
    end
    idle_wait();
    if_req = 1; ls_req = 1; if_addr = 8'h10; ls_addr = 8'h33;
    wait_gnt(g, t0);
    chk("both_first_ls", g, 1);
    ls_req = 0;
    wait_gnt(g, t1);
    chk("both_second_if", g, 0);
    chk("both_gap", t1 - t0, RL + 3);
    if_req = 0;
    idle_wait();
    if_req = 1; ls_req = 1; ls_addr = 8'h40;
    order = 0;
    for (int k = 0; k < 10; k++) begin
      wait_gnt(g, t0);
      order = {order[8:0], g};
    end
    chk("starve_order", order, 10'b1111011110);
    if_req = 0; ls_req = 0;
    idle_wait();
    reset3 = 1; ls_req3 = 1; ls_addr3 = 8'h10;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (c == 0) chk("r3_gnt", ls_gnt3, 1);
      if (c == 1) chk("r3_mem_en", mem_en3, 1);
      if (c == 2) chk("r3_wait", {busy3, mem_en3}, 2'b10);
      if (c == 0) begin @(posedge clk); #1 ls_req3 = 0; end
    end
    @(posedge clk);
    #1 reset3 = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("r3_abort", {ls_rvalid3, busy3, ls_rdata3}, 0);
    end
    @(posedge clk);
    #1 reset3 = 1; ls_req3 = 1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 0) chk("r3b_gnt", ls_gnt3, 1);
      if (c > 0 && c < 5) chk("r3b_norv", ls_rvalid3, 0);
      if (c == 5) chk("r3b_data", {ls_rvalid3, ls_rdata3}, {1'b1, 16'hBEEF});
      if (c == 0) begin @(posedge clk); #1 ls_req3 = 0; end
    end
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
